// File: rtl/fifo_rd_pkg.sv
// Shared types for the async-FIFO read master: FSM states, buffer entry layout
// and default widths.
package fifo_rd_pkg;

  localparam int RD_WIDTH = 8;
  localparam int RD_LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

  typedef struct packed {
    logic [RD_WIDTH-1:0] data;
    logic                last;
  } rd_entry_t;

endpackage

// File: rtl/fifo_read_master_if.sv
// Bundles the FIFO read port, the burst command channel and the output stream
// of the read master.
interface fifo_read_master_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
);

  logic             REMPTY;
  logic [WIDTH-1:0] RDATA;
  logic             RINC;

  logic             CMD_VALID;
  logic             CMD_READY;
  logic [LEN_W-1:0] CMD_LEN;

  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OUT_DATA;
  logic             OUT_LAST;

  logic             DONE;
  logic [LEN_W-1:0] RD_COUNT;

  modport master (
    input  REMPTY, RDATA, CMD_VALID, CMD_LEN, OUT_READY,
    output RINC, CMD_READY, OUT_VALID, OUT_DATA, OUT_LAST, DONE, RD_COUNT
  );

  modport slave (
    output REMPTY, RDATA, CMD_VALID, CMD_LEN, OUT_READY,
    input  RINC, CMD_READY, OUT_VALID, OUT_DATA, OUT_LAST, DONE, RD_COUNT
  );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer between the FIFO pop and the downstream stream.
// Head entry is always presented; push and pop may happen in the same cycle.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter type entry_t = rd_entry_t
) (
  input  logic       RCLK,
  input  logic       RRST,
  input  logic       push,
  input  entry_t     push_entry,
  input  logic       pop,
  output entry_t     head_entry,
  output logic [1:0] occupancy
);

  entry_t     head_q;
  entry_t     tail_q;
  logic [1:0] count_q;
  logic       do_pop;

  assign do_pop     = pop && (count_q != 2'd0);
  assign head_entry = head_q;
  assign occupancy  = count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge RCLK) begin
    if (RRST) begin
      head_q  <= '0;
      count_q <= 2'd0;
    end else begin
      unique case ({push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= push_entry;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) head_q <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          head_q <= (count_q == 2'd2) ? tail_q : push_entry;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the tail is only meaningful while count_q says so, so it carries no
  // reset and stays a plain enable flop.
  always_ff @(posedge RCLK) begin
    if ((push && !do_pop && count_q == 2'd1) || (push && do_pop && count_q == 2'd2))
      tail_q <= push_entry;
  end

endmodule

// File: rtl/fifo_read_master.sv
// Read-side burst master: pops CMD_LEN words from the async FIFO and streams
// them out with a last marker, then pulses DONE.
module fifo_read_master
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = RD_WIDTH,
  parameter int LEN_W = RD_LEN_W
) (
  input logic RCLK,
  input logic RRST,
  fifo_read_master_if.master bus
);

  rd_state_t        state_q, state_d;
  logic [LEN_W-1:0] remaining_q;
  logic [LEN_W-1:0] rd_count_q;

  rd_entry_t        head;
  rd_entry_t        push_entry;
  logic [1:0]       occ;
  logic [WIDTH-1:0] out_data;

  logic cmd_ready, rinc, done, accept, out_valid, out_pop, last_pop;

  assign accept     = bus.CMD_VALID && cmd_ready;
  assign out_valid  = (occ != 2'd0);
  assign out_pop    = out_valid && bus.OUT_READY;
  assign last_pop   = rinc && (remaining_q == LEN_W'(1));
  assign push_entry = '{data: bus.RDATA, last: (remaining_q == LEN_W'(1))};

  always_ff @(posedge RCLK) begin
    if (RRST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (bus.CMD_LEN == '0) ? DONE : READ;
      READ:    if (last_pop) state_d = FLUSH;
      FLUSH:   if (out_pop && head.last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pops depend only on registered occupancy, never on OUT_READY.
  always_comb begin
    cmd_ready = 1'b0;
    rinc      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE:    cmd_ready = !RRST;
      READ:    rinc = !RRST && !bus.REMPTY && (remaining_q != '0) && (occ < 2'd2);
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge RCLK) begin
    if (RRST) begin
      remaining_q <= '0;
      rd_count_q  <= '0;
    end else if (accept) begin
      remaining_q <= bus.CMD_LEN;
      rd_count_q  <= '0;
    end else if (rinc) begin
      remaining_q <= remaining_q - LEN_W'(1);
      rd_count_q  <= rd_count_q + LEN_W'(1);
    end
  end

  fifo_rd_skid #(
    .entry_t (rd_entry_t)
  ) u_skid (
    .RCLK       (RCLK),
    .RRST       (RRST),
    .push       (rinc),
    .push_entry (push_entry),
    .pop        (out_pop),
    .head_entry (head),
    .occupancy  (occ)
  );

  assign out_data      = head.data;
  assign bus.RINC      = rinc;
  assign bus.CMD_READY = cmd_ready;
  assign bus.OUT_VALID = out_valid;
  assign bus.OUT_DATA  = out_data;
  assign bus.OUT_LAST  = head.last;
  assign bus.DONE      = done;
  assign bus.RD_COUNT  = rd_count_q;

endmodule

// File: tb/tb_fifo_read_master.sv
// Directed bench for fifo_read_master: a queue models the FIFO, a scoreboard
// monitor checks every delivered word, DONE timing and output stability.
module tb_fifo_read_master;
  import fifo_rd_pkg::*;

  logic RCLK = 1'b0;
  logic RRST;
  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;

  fifo_read_master_if #(.WIDTH(8), .LEN_W(8)) bus ();

  fifo_read_master #(.WIDTH(8), .LEN_W(8)) dut (
    .RCLK (RCLK),
    .RRST (RRST),
    .bus  (bus)
  );

  always #5 RCLK = ~RCLK;
  always @(posedge RCLK) cyc <= cyc + 1;

  logic [7:0] fifo_q[$];
  rd_entry_t  exp_q[$];
  int         pop_cyc_q[$];
  int         pop_total  = 0;
  int         done_count = 0;
  int         done_cyc   = 0;
  int         accept_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    failed++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  function automatic void fifo_update();
    bus.REMPTY = (fifo_q.size() == 0);
    bus.RDATA  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endfunction

  task automatic fifo_push(input logic [7:0] d);
    fifo_q.push_back(d);
    fifo_update();
  endtask

  task automatic expect_word(input logic [7:0] d, input logic last);
    exp_q.push_back('{data: d, last: last});
  endtask

  task automatic step();
    @(posedge RCLK);
    #2;
  endtask

  task automatic send_cmd(input logic [7:0] len);
    int b = 0;
    bus.CMD_VALID = 1'b1;
    bus.CMD_LEN   = len;
    @(negedge RCLK);
    while (!bus.CMD_READY && b < 200) begin
      @(negedge RCLK);
      b++;
    end
    if (!bus.CMD_READY) fail_now("cmd_accept_timeout");
    @(posedge RCLK);
    #2;
    bus.CMD_VALID = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int b = 0;
    while (done_count < target && b < budget) begin
      step();
      b++;
    end
    if (done_count < target) fail_now("done_timeout");
  endtask

  // FIFO model: RINC sampled mid-cycle, the head word leaves just after the edge.
  initial begin : fifo_model
    logic pop_now;
    forever begin
      @(negedge RCLK);
      pop_now = bus.RINC;
      if (pop_now) check("rinc_while_empty", bus.REMPTY, 1'b0);
      @(posedge RCLK);
      #1;
      if (pop_now && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        pop_total++;
        pop_cyc_q.push_back(cyc);
      end
      fifo_update();
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    rd_entry_t  e;
    logic       exp_done = 1'b0;
    logic       held     = 1'b0;
    logic [7:0] held_data;
    logic       held_last;
    forever begin
      @(negedge RCLK);
      if (RRST) begin
        check("rinc_in_reset", bus.RINC, 1'b0);
        check("cmd_ready_in_reset", bus.CMD_READY, 1'b0);
        exp_done = 1'b0;
        held     = 1'b0;
      end else begin
        if (exp_done || bus.DONE) check("done_timing", bus.DONE, exp_done);
        exp_done = 1'b0;
        if (bus.DONE) begin
          done_count++;
          done_cyc = cyc;
        end
        if (bus.CMD_VALID && bus.CMD_READY) begin
          accept_cyc = cyc;
          if (bus.CMD_LEN == 8'd0) exp_done = 1'b1;
        end
        if (held) begin
          check("hold_valid", bus.OUT_VALID, 1'b1);
          check("hold_data", bus.OUT_DATA, held_data);
          check("hold_last", bus.OUT_LAST, held_last);
        end
        held      = bus.OUT_VALID && !bus.OUT_READY;
        held_data = bus.OUT_DATA;
        held_last = bus.OUT_LAST;
        if (bus.OUT_VALID && bus.OUT_READY) begin
          if (exp_q.size() == 0) fail_now("unexpected_output");
          else begin
            e = exp_q.pop_front();
            check("out_data", bus.OUT_DATA, e.data);
            check("out_last", bus.OUT_LAST, e.last);
            if (e.last) exp_done = 1'b1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int d0, p0, rcyc;
    RRST          = 1'b1;
    bus.CMD_VALID = 1'b0;
    bus.CMD_LEN   = 8'd0;
    bus.OUT_READY = 1'b0;
    fifo_update();
    repeat (3) step();
    RRST = 1'b0;
    #1;
    check("rst_out_valid", bus.OUT_VALID, 1'b0);
    check("rst_out_data", bus.OUT_DATA, 8'h00);
    check("rst_out_last", bus.OUT_LAST, 1'b0);
    check("rst_done", bus.DONE, 1'b0);
    check("rst_rd_count", bus.RD_COUNT, 8'd0);
    check("rst_cmd_ready", bus.CMD_READY, 1'b1);

    // Basic 4-word burst at full rate.
    bus.OUT_READY = 1'b1;
    fifo_push(8'h11); fifo_push(8'h22); fifo_push(8'h33); fifo_push(8'h44);
    expect_word(8'h11, 1'b0); expect_word(8'h22, 1'b0);
    expect_word(8'h33, 1'b0); expect_word(8'h44, 1'b1);
    d0 = done_count; p0 = pop_total; pop_cyc_q.delete();
    send_cmd(8'd4);
    wait_done(d0 + 1, 50);
    step();
    check("t1_pops", pop_total - p0, 4);
    check("t1_pop_log", pop_cyc_q.size(), 4);
    if (pop_cyc_q.size() == 4) begin
      check("t1_cmd_to_rinc", pop_cyc_q[0] - accept_cyc, 2);
      check("t1_consecutive", pop_cyc_q[3] - pop_cyc_q[0], 3);
    end
    check("t1_rd_count", bus.RD_COUNT, 8'd4);
    check("t1_done_once", done_count - d0, 1);

    // FIFO runs empty after the first word; popping resumes when it refills.
    fifo_push(8'hA1);
    expect_word(8'hA1, 1'b0); expect_word(8'hA2, 1'b0); expect_word(8'hA3, 1'b1);
    d0 = done_count; p0 = pop_total; pop_cyc_q.delete();
    send_cmd(8'd3);
    repeat (7) step();
    check("t2_stalled_pops", pop_total - p0, 1);
    rcyc = cyc;
    fifo_push(8'hA2); fifo_push(8'hA3);
    wait_done(d0 + 1, 50);
    repeat (3) step();
    check("t2_pops", pop_total - p0, 3);
    if (pop_cyc_q.size() >= 2) check("t2_resume", pop_cyc_q[1] - rcyc, 1);
    check("t2_rd_count", bus.RD_COUNT, 8'd3);
    check("t2_done_once", done_count - d0, 1);

    // Back-pressure: buffer fills to 2, then pops stop until the consumer drains.
    bus.OUT_READY = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      fifo_push(8'h30 + 8'(i));
      expect_word(8'h30 + 8'(i), i == 6);
    end
    d0 = done_count; p0 = pop_total;
    send_cmd(8'd6);
    repeat (10) step();
    check("t3_two_pops", pop_total - p0, 2);
    @(negedge RCLK);
    check("t3_rinc_low", bus.RINC, 1'b0);
    check("t3_head_data", bus.OUT_DATA, 8'h31);
    step();
    bus.OUT_READY = 1'b1;
    wait_done(d0 + 1, 100);
    step();
    check("t3_rd_count", bus.RD_COUNT, 8'd6);
    check("t3_all_delivered", exp_q.size(), 0);
    check("t3_done_once", done_count - d0, 1);

    // Zero-length burst.
    d0 = done_count; p0 = pop_total;
    send_cmd(8'd0);
    repeat (3) step();
    check("t4_no_pops", pop_total - p0, 0);
    check("t4_done_once", done_count - d0, 1);
    check("t4_rd_count", bus.RD_COUNT, 8'd0);

    // Reset in the middle of a burst.
    for (int i = 1; i <= 5; i++) begin
      fifo_push(8'h50 + 8'(i));
      expect_word(8'h50 + 8'(i), i == 5);
    end
    d0 = done_count; p0 = pop_total;
    send_cmd(8'd5);
    begin
      int b = 0;
      while (pop_total - p0 < 2 && b < 20) begin
        step();
        b++;
      end
    end
    RRST = 1'b1;
    step();
    RRST = 1'b0;
    exp_q.delete();
    #1;
    check("t5_out_valid", bus.OUT_VALID, 1'b0);
    check("t5_rinc", bus.RINC, 1'b0);
    check("t5_rd_count", bus.RD_COUNT, 8'd0);
    repeat (5) step();
    check("t5_no_done", done_count - d0, 0);
    check("t5_pops", pop_total - p0, 2);
    expect_word(8'h53, 1'b1);
    send_cmd(8'd1);
    wait_done(d0 + 1, 50);
    step();
    check("t5_new_rd_count", bus.RD_COUNT, 8'd1);
    check("t5_new_delivered", exp_q.size(), 0);
    fifo_q.delete();
    fifo_update();

    // Command held while busy is taken the cycle after DONE.
    fifo_push(8'h61); fifo_push(8'h62); fifo_push(8'h71);
    expect_word(8'h61, 1'b0); expect_word(8'h62, 1'b1); expect_word(8'h71, 1'b1);
    d0 = done_count;
    send_cmd(8'd2);
    bus.CMD_VALID = 1'b1;
    bus.CMD_LEN   = 8'd1;
    @(negedge RCLK);
    check("t6_cmd_ready_busy", bus.CMD_READY, 1'b0);
    send_cmd(8'd1);
    check("t6_first_done", done_count - d0, 1);
    check("t6_accept_after_done", accept_cyc - done_cyc, 1);
    wait_done(d0 + 2, 50);
    step();
    check("t6_rd_count", bus.RD_COUNT, 8'd1);
    check("t6_delivered", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
